// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries decode-stage predictions through D->E and E->M,
// resolves them in M and produces redirect/flush plus predictor training feedback.
// Optional performance counters are enabled with `define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallE,
    input  logic            flushE,
    input  logic            stallM,
    input  logic            flushM,
    input  logic            branchD,
    input  logic [PC_W-1:0] pcD,
    input  logic [PC_W-1:0] branch_targetD,
    input  logic            pred_takeD,
    input  logic            Lpred_takeD,
    input  logic            Gpred_takeD,
    input  logic            actual_takeE,
`ifdef BRU_PERF_CNT_EN
    input  logic             perf_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] lcorrect_cnt,
    output logic [CNT_W-1:0] gcorrect_cnt,
`endif
    output logic            branchM,
    output logic [PC_W-1:0] pcM,
    output logic            actual_takeM,
    output logic            pred_takeM,
    output logic            Lpred_takeM,
    output logic            Gpred_takeM,
    output logic            mispredictM,
    output logic            redirect_validM,
    output logic [PC_W-1:0] redirect_pcM,
    output logic            flush_front
);

    logic            branchE;
    logic [PC_W-1:0] pcE;
    logic [PC_W-1:0] targetE;
    logic            pred_takeE;
    logic            Lpred_takeE;
    logic            Gpred_takeE;
    logic [PC_W-1:0] targetM;
    logic [PC_W-1:0] pc_plus4M;

    // D->E: prediction bits of non-branches are forced to 0 so they never mispredict.
    always_ff @(posedge clk) begin
        if (rst || flushE || flush_front) begin
            branchE     <= 1'b0;
            pcE         <= '0;
            targetE     <= '0;
            pred_takeE  <= 1'b0;
            Lpred_takeE <= 1'b0;
            Gpred_takeE <= 1'b0;
        end else if (!stallE) begin
            branchE     <= branchD;
            pcE         <= pcD;
            targetE     <= branch_targetD;
            pred_takeE  <= pred_takeD & branchD;
            Lpred_takeE <= Lpred_takeD & branchD;
            Gpred_takeE <= Gpred_takeD & branchD;
        end
    end

    // E->M: a redirect bubbles M so the wrong-path E instruction never resolves.
    always_ff @(posedge clk) begin
        if (rst || flushM || redirect_validM) begin
            branchM      <= 1'b0;
            pcM          <= '0;
            targetM      <= '0;
            actual_takeM <= 1'b0;
            pred_takeM   <= 1'b0;
            Lpred_takeM  <= 1'b0;
            Gpred_takeM  <= 1'b0;
        end else if (!stallM) begin
            branchM      <= branchE;
            pcM          <= pcE;
            targetM      <= targetE;
            actual_takeM <= actual_takeE & branchE;
            pred_takeM   <= pred_takeE;
            Lpred_takeM  <= Lpred_takeE;
            Gpred_takeM  <= Gpred_takeE;
        end
    end

    assign mispredictM     = branchM & (actual_takeM ^ pred_takeM);
    assign redirect_validM = mispredictM & ~stallM;
    assign flush_front     = redirect_validM;
    assign pc_plus4M       = pcM + PC_W'(4);
    assign redirect_pcM    = (redirect_validM && actual_takeM) ? targetM : pc_plus4M;

`ifdef BRU_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            branch_cnt   <= '0;
            mispred_cnt  <= '0;
            lcorrect_cnt <= '0;
            gcorrect_cnt <= '0;
        end else if (branchM && !stallM) begin
            branch_cnt   <= sat_inc(branch_cnt, 1'b1);
            mispred_cnt  <= sat_inc(mispred_cnt, mispredictM);
            lcorrect_cnt <= sat_inc(lcorrect_cnt, Lpred_takeM == actual_takeM);
            gcorrect_cnt <= sat_inc(gcorrect_cnt, Gpred_takeM == actual_takeM);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, then randomized traffic
// against an instruction-level reference model.
module tb_branch_resolve_unit;

`ifdef BRU_PERF_CNT_EN
    localparam int CW = 6;
`else
    localparam int CW = 32;
`endif

    logic        clk = 1'b0;
    logic        rst, stallE, flushE, stallM, flushM, branchD;
    logic [31:0] pcD, branch_targetD;
    logic        pred_takeD, Lpred_takeD, Gpred_takeD, actual_takeE;
    logic        branchM, actual_takeM, pred_takeM, Lpred_takeM, Gpred_takeM;
    logic        mispredictM, redirect_validM, flush_front;
    logic [31:0] pcM, redirect_pcM;
`ifdef BRU_PERF_CNT_EN
    logic          perf_clr;
    logic [CW-1:0] branch_cnt, mispred_cnt, lcorrect_cnt, gcorrect_cnt;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.PC_W(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
        .branchD(branchD), .pcD(pcD), .branch_targetD(branch_targetD),
        .pred_takeD(pred_takeD), .Lpred_takeD(Lpred_takeD), .Gpred_takeD(Gpred_takeD),
        .actual_takeE(actual_takeE),
`ifdef BRU_PERF_CNT_EN
        .perf_clr(perf_clr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
        .lcorrect_cnt(lcorrect_cnt), .gcorrect_cnt(gcorrect_cnt),
`endif
        .branchM(branchM), .pcM(pcM), .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
        .Lpred_takeM(Lpred_takeM), .Gpred_takeM(Gpred_takeM), .mispredictM(mispredictM),
        .redirect_validM(redirect_validM), .redirect_pcM(redirect_pcM), .flush_front(flush_front)
    );

    typedef struct {
        logic        r, se, fe, sm, fm, br;
        logic [31:0] pc, tgt;
        logic        p, l, g, a;
        logic        e_bm;
        logic [31:0] e_pc;
        logic        e_mis, e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    // One in-flight instruction as the model sees it.
    typedef struct {
        logic        valid;
        logic [31:0] pc, tgt;
        logic        p, l, g, a;
    } instr_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    vec_t   vecs[$];
    instr_t in_e, in_m;
    longint cnt_br, cnt_mis, cnt_l, cnt_g;
    logic   perf_clr_v;

    function automatic vec_t mk(input logic r, se, fe, sm, fm, br, input logic [31:0] pc, tgt,
                                input logic p, l, g, a, input logic ebm, input logic [31:0] epc,
                                input logic emis, erv, input logic [31:0] erpc);
        vec_t v;
        v.r = r; v.se = se; v.fe = fe; v.sm = sm; v.fm = fm; v.br = br;
        v.pc = pc; v.tgt = tgt; v.p = p; v.l = l; v.g = g; v.a = a;
        v.e_bm = ebm; v.e_pc = epc; v.e_mis = emis; v.e_rv = erv; v.e_rpc = erpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; stallE = v.se; flushE = v.fe; stallM = v.sm; flushM = v.fm;
        branchD = v.br; pcD = v.pc; branch_targetD = v.tgt;
        pred_takeD = v.p; Lpred_takeD = v.l; Gpred_takeD = v.g; actual_takeE = v.a;
    endtask

    function automatic logic model_mis();
        return in_m.valid && (in_m.a != in_m.p);
    endfunction

    // Advance the reference by one clock using the currently driven inputs.
    task automatic model_step();
        instr_t nothing;
        instr_t from_d;
        logic   redirect;
        longint sat;
        nothing  = '{valid: 1'b0, pc: 32'd0, tgt: 32'd0, p: 1'b0, l: 1'b0, g: 1'b0, a: 1'b0};
        redirect = model_mis() && !stallM;
        sat      = (longint'(1) << CW) - 1;
        if (rst || perf_clr_v) begin
            cnt_br = 0; cnt_mis = 0; cnt_l = 0; cnt_g = 0;
        end else if (in_m.valid && !stallM) begin
            cnt_br  = (cnt_br + 1 > sat) ? sat : cnt_br + 1;
            if (model_mis())        cnt_mis = (cnt_mis + 1 > sat) ? sat : cnt_mis + 1;
            if (in_m.l == in_m.a)   cnt_l   = (cnt_l + 1 > sat) ? sat : cnt_l + 1;
            if (in_m.g == in_m.a)   cnt_g   = (cnt_g + 1 > sat) ? sat : cnt_g + 1;
        end
        from_d = nothing;
        from_d.valid = branchD; from_d.pc = pcD; from_d.tgt = branch_targetD;
        if (branchD) begin
            from_d.p = pred_takeD; from_d.l = Lpred_takeD; from_d.g = Gpred_takeD;
        end
        if (rst) begin
            in_m = nothing;
            in_e = nothing;
        end else begin
            if (flushM || redirect) in_m = nothing;
            else if (!stallM) begin
                in_m   = in_e;
                in_m.a = actual_takeE && in_e.valid;
            end
            if (flushE || redirect) in_e = nothing;
            else if (!stallE) in_e = from_d;
        end
    endtask

    task automatic check_model();
        logic        rv;
        logic [31:0] rpc;
        rv  = model_mis() && !stallM;
        rpc = (rv && in_m.a) ? in_m.tgt : in_m.pc + 32'd4;
        chk("branchM", 32'(branchM), 32'(in_m.valid));
        chk("pcM", pcM, in_m.pc);
        chk("actual_takeM", 32'(actual_takeM), 32'(in_m.a));
        chk("pred_takeM", 32'(pred_takeM), 32'(in_m.p));
        chk("Lpred_takeM", 32'(Lpred_takeM), 32'(in_m.l));
        chk("Gpred_takeM", 32'(Gpred_takeM), 32'(in_m.g));
        chk("mispredictM", 32'(mispredictM), 32'(model_mis()));
        chk("redirect_validM", 32'(redirect_validM), 32'(rv));
        chk("flush_front", 32'(flush_front), 32'(rv));
        chk("redirect_pcM", redirect_pcM, rpc);
`ifdef BRU_PERF_CNT_EN
        chk("branch_cnt", 32'(branch_cnt), 32'(cnt_br));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(cnt_mis));
        chk("lcorrect_cnt", 32'(lcorrect_cnt), 32'(cnt_l));
        chk("gcorrect_cnt", 32'(gcorrect_cnt), 32'(cnt_g));
`endif
    endtask

    initial begin
        vec_t v;
        in_e = '{valid: 1'b0, pc: 32'd0, tgt: 32'd0, p: 1'b0, l: 1'b0, g: 1'b0, a: 1'b0};
        in_m = in_e;
        cnt_br = 0; cnt_mis = 0; cnt_l = 0; cnt_g = 0;
        perf_clr_v = 1'b0;
`ifdef BRU_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        drive(mk(1,0,0,0,0,0, 32'h0, 32'h0, 0,0,0,0, 0, 32'h0, 0,0, 32'h4));

        //         r se fe sm fm br pcD           target        p l g a   bM pcM           mis rv rpc
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h100,      32'h200,      1,1,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h100,      0,0, 32'h104));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h300,      32'h340,      0,0,1,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h300,      1,1, 32'h340));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        // mispredicted taken held by stallM: redirect waits, then fires once
        vecs.push_back(mk(0,0,0,0,0,1, 32'h3FC,      32'h500,      1,1,1,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,1,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h3FC,      1,0, 32'h400));
        vecs.push_back(mk(0,0,0,1,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h3FC,      1,0, 32'h400));
        vecs.push_back(mk(0,0,0,1,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h3FC,      1,0, 32'h400));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'h3FC,      1,1, 32'h400));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        // flushE as the branch would enter E
        vecs.push_back(mk(0,0,1,0,0,1, 32'h600,      32'h700,      0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        // PC wrap on a not-taken redirect
        vecs.push_back(mk(0,0,0,0,0,1, 32'hFFFFFFFC, 32'h10,       1,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  1, 32'hFFFFFFFC, 1,1, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        // back-to-back: the younger branch is on the wrong path and must vanish
        vecs.push_back(mk(0,0,0,0,0,1, 32'h800,      32'h880,      0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h900,      32'h980,      0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  1, 32'h800,      1,1, 32'h880));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        // reset with a mispredicting branch in E discards it
        vecs.push_back(mk(0,0,0,0,0,1, 32'hA00,      32'hA80,      0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(1,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,1,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0,        32'h0,        0,0,0,0,  0, 32'h0,        0,0, 32'h4));

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #3;
            chk($sformatf("v%0d.branchM", i), 32'(branchM), 32'(vecs[i].e_bm));
            chk($sformatf("v%0d.pcM", i), pcM, vecs[i].e_pc);
            chk($sformatf("v%0d.mispredictM", i), 32'(mispredictM), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d.redirect_validM", i), 32'(redirect_validM), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d.flush_front", i), 32'(flush_front), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d.redirect_pcM", i), redirect_pcM, vecs[i].e_rpc);
            model_step();
        end

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            v.r  = ($urandom_range(0, 199) == 0);
            v.se = ($urandom_range(0, 9) < 2);
            v.fe = ($urandom_range(0, 19) == 0);
            v.sm = ($urandom_range(0, 9) < 2);
            v.fm = ($urandom_range(0, 19) == 0);
            v.br = ($urandom_range(0, 9) < 6);
            v.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            v.tgt = $urandom() & 32'hFFFFFFFC;
            v.p = 1'($urandom_range(0, 1)); v.l = 1'($urandom_range(0, 1));
            v.g = 1'($urandom_range(0, 1)); v.a = 1'($urandom_range(0, 1));
            drive(v);
            perf_clr_v = ($urandom_range(0, 299) == 0);
`ifdef BRU_PERF_CNT_EN
            perf_clr = perf_clr_v;
`endif
            #3;
            check_model();
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute/memory-side partner of the fetch/decode branch predictor.
- Carries each decode-stage prediction (final, local, global), the branch PC and the branch target through the D->E and E->M pipeline registers.
- Captures the actual branch outcome in E and resolves it in M.
- Outputs the M-stage feedback the predictor trains on: branchM, pcM, actual_takeM, pred_takeM, Lpred_takeM, Gpred_takeM.
- Also outputs the misprediction redirect PC and the front-end flush request.

Parameters:
- PC_W, 32, width of PC and target paths.
- CNT_W, 32, width of each performance counter (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stallE  input  1  hold the D->E register
- flushE  input  1  load a bubble into the D->E register (from the hazard unit)
- stallM  input  1  hold the E->M register
- flushM  input  1  load a bubble into the E->M register
- branchD  input  1  instruction in D is a conditional branch
- pcD  input  PC_W  PC of the D instruction
- branch_targetD  input  PC_W  taken target computed in D
- pred_takeD  input  1  final tournament prediction
- Lpred_takeD  input  1  local predictor prediction
- Gpred_takeD  input  1  global predictor prediction
- actual_takeE  input  1  branch condition result from the E-stage comparator
- branchM  output  1  valid branch in M
- pcM  output  PC_W  PC of the M branch
- actual_takeM  output  1  resolved outcome
- pred_takeM  output  1  final prediction carried to M
- Lpred_takeM  output  1  local prediction carried to M
- Gpred_takeM  output  1  global prediction carried to M
- mispredictM  output  1  branchM & (actual_takeM != pred_takeM)
- redirect_validM  output  1  PC redirect this cycle
- redirect_pcM  output  PC_W  corrected fetch PC
- flush_front  output  1  flush F/D/E due to misprediction

Behaviour:
- Two register stages:
  - D->E holds {branch, pc, target, pred, Lpred, Gpred}.
  - E->M holds the same fields plus actual_take, captured from actual_takeE.
- Per-stage priority: rst > flush > stall > load.
- Flush and reset clear all fields to 0, which is a bubble.
- Stall holds all fields.
- The D->E stage is also flushed when flush_front=1.
- On a redirect edge with stallM=0, the E->M stage loads a bubble: the wrong-path E instruction must not reach M.
- Latency: a branch in D at cycle t appears in M at t+2 with no stalls; each stall cycle adds one.
- Combinational M outputs:
  - mispredictM = branchM & (actual_takeM ^ pred_takeM).
  - redirect_validM = mispredictM & ~stallM.
  - flush_front = redirect_validM.
- redirect_pcM:
  - actual_takeM=1: the M target.
  - actual_takeM=0: pcM + 4, modulo 2^PC_W (0xFFFFFFFC wraps to 0x00000000).
  - When redirect_validM=0: redirect_pcM = pcM + 4.
- Stall while mispredicting: mispredictM stays 1 but redirect_validM stays 0 until stallM drops. The redirect then fires exactly once, because the M stage is bubbled on that edge.
- Non-branch instructions: branch=0. Non-branch prediction fields carried as 0, giving mispredictM=0.
- Reset values:
  - All registered fields are 0, so every output is 0.
  - redirect_pcM = 0x00000004 (pcM=0, actual_takeM=0).
- Reset mid-operation: all in-flight predictions are discarded and no redirect is issued on the reset edge.
- Predictor training uses only M outputs qualified by branchM; this block does not gate on stallM for those outputs.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds:
  - input perf_clr (1 bit).
  - outputs branch_cnt, mispred_cnt, lcorrect_cnt, gcorrect_cnt (each CNT_W).
- Counting:
  - Counters advance only on branchM & ~stallM.
  - branch_cnt +1 every counted branch.
  - mispred_cnt +1 if mispredictM.
  - lcorrect_cnt +1 if Lpred_takeM == actual_takeM.
  - gcorrect_cnt +1 if Gpred_takeM == actual_takeM.
- Counters saturate at all-ones.
- rst and perf_clr clear all counters to 0; perf_clr wins over a simultaneous increment.
- When not defined, these ports and this logic are absent and the rest of the behaviour is unchanged.

Test Plan:
- Reset check: assert rst for 2 cycles, then release -> all outputs 0, redirect_pcM=0x4, no redirect.
- Correct taken prediction: branchD=1, pcD=0x100, target=0x200, pred=1, actual_takeE=1 -> at t+2 branchM=1, pcM=0x100, mispredictM=0, flush_front=0.
- Wrong not-taken prediction: pred=0, actual_takeE=1, target=0x340 -> redirect_validM=1, redirect_pcM=0x340, flush_front=1 for 1 cycle, next cycle branchM=0.
- Wrong taken prediction with stall: pred=1, actual=0, pcD=0x3FC, stallM held for 3 cycles -> redirect_validM=0 during the stall, then 1 for exactly 1 cycle with redirect_pcM=0x400.
- Flushes and PC wrap: flushE on the cycle the branch enters E -> branch never reaches M. pcM=0xFFFFFFFC mispredicted not-taken -> redirect_pcM=0x0.
- Counters (BRU_PERF_CNT_EN defined): 5 branches with 2 mispredicts, L right 3 times, G right 4 times -> counts 5/2/3/4; then perf_clr -> all 0; preload to all-ones -> count holds.
